// File: rtl/vector_lane_sequencer.sv
// Shared-ALU vector sequencer: one LANE_WIDTH lane per negedge
// for VADD/VMOV/VMOVI/VCOMPMOV/VCOMPMOVI, valid/ready both sides.
// Ports: I_CLOCK, I_RESET (async high); upstream I_Valid/O_Ready,
//  I_Opcode, I_VSrc1Value, I_VSrc2Value, I_VDestValue, I_Imm,
//  I_LaneSel; downstream O_Valid/I_Ready, O_VALUOut, O_Opcode;
//  status O_LaneIdx (next lane), O_Busy (RUN or DONE).
module vector_lane_sequencer #(
  parameter int LANE_WIDTH   = 16,
  parameter int NUM_LANES    = 4,
  parameter int LANE_IDX_W   = 2,
  parameter int OPCODE_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] OP_VADD      = 8'h70,
  parameter logic [OPCODE_WIDTH-1:0] OP_VMOV      = 8'h71,
  parameter logic [OPCODE_WIDTH-1:0] OP_VMOVI     = 8'h72,
  parameter logic [OPCODE_WIDTH-1:0] OP_VCOMPMOV  = 8'h73,
  parameter logic [OPCODE_WIDTH-1:0] OP_VCOMPMOVI = 8'h74
) (
  input  logic                            I_CLOCK,
  input  logic                            I_RESET,
  input  logic                            I_Valid,
  output logic                            O_Ready,
  input  logic [OPCODE_WIDTH-1:0]         I_Opcode,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] I_VSrc1Value,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] I_VSrc2Value,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] I_VDestValue,
  input  logic [LANE_WIDTH-1:0]           I_Imm,
  input  logic [LANE_IDX_W-1:0]           I_LaneSel,
  output logic                            O_Valid,
  input  logic                            I_Ready,
  output logic [LANE_WIDTH*NUM_LANES-1:0] O_VALUOut,
  output logic [OPCODE_WIDTH-1:0]         O_Opcode,
  output logic [LANE_IDX_W-1:0]           O_LaneIdx,
  output logic                            O_Busy
);

  localparam int VW = LANE_WIDTH * NUM_LANES;
  localparam logic [LANE_IDX_W-1:0] LAST =
    LANE_IDX_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [VW-1:0]         src1_q;
  logic [VW-1:0]         src2_q;
  logic [LANE_WIDTH-1:0] imm_q;
  logic                  single_q;

  logic                  accept;
  logic                  in_full;
  logic                  in_single;
  logic                  run_last;
  logic                  use_add;
  logic                  use_imm;
  logic [LANE_WIDTH-1:0] lane_a;
  logic [LANE_WIDTH-1:0] lane_b;
  logic [LANE_WIDTH-1:0] lane_res;

  assign in_full   = (I_Opcode == OP_VADD)
                   || (I_Opcode == OP_VMOV)
                   || (I_Opcode == OP_VMOVI);
  assign in_single = (I_Opcode == OP_VCOMPMOV)
                   || (I_Opcode == OP_VCOMPMOVI);
  assign accept    = I_Valid && O_Ready;
  assign run_last  = single_q || (O_LaneIdx == LAST);

  assign use_add = (O_Opcode == OP_VADD);
  assign use_imm = (O_Opcode == OP_VMOVI)
                 || (O_Opcode == OP_VCOMPMOVI);

  assign lane_a =
    src1_q[O_LaneIdx*LANE_WIDTH +: LANE_WIDTH];
  assign lane_b =
    src2_q[O_LaneIdx*LANE_WIDTH +: LANE_WIDTH];

  // lanes are independent: the sum is cut to LANE_WIDTH, no carry out
  always_comb begin
    lane_res = lane_a;
    if (use_imm)
      lane_res = imm_q;
    else if (use_add)
      lane_res = lane_a + lane_b;
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (in_full || in_single) ? RUN : DONE;
      end
      RUN: begin
        if (run_last)
          state_d = DONE;
      end
      DONE: begin
        if (I_Ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // O_Ready is masked by reset so nothing is taken while it is held
  always_comb begin
    O_Ready = (state_q == IDLE) && !I_RESET;
    O_Valid = (state_q == DONE);
    O_Busy  = (state_q == RUN) || (state_q == DONE);
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      single_q  <= 1'b0;
      O_VALUOut <= '0;
      O_Opcode  <= '0;
      O_LaneIdx <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            src1_q    <= I_VSrc1Value;
            src2_q    <= I_VSrc2Value;
            imm_q     <= I_Imm;
            single_q  <= in_single;
            O_VALUOut <= I_VDestValue;
            O_Opcode  <= I_Opcode;
            O_LaneIdx <= in_single ? I_LaneSel : '0;
          end
        end
        RUN: begin
          O_VALUOut[O_LaneIdx*LANE_WIDTH +: LANE_WIDTH]
            <= lane_res;
          if (!run_last)
            O_LaneIdx <= O_LaneIdx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
